// File: rtl/pcis_stream_bridge.sv
// pcis_stream_bridge: AXI4 write/read slave bridged to kernel streams
// through an inbound and an outbound synchronous FIFO.
module pcis_stream_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // DEPTH is a power of two, so the top count bit alone marks full
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module pcis_stream_bridge #(
    parameter int DATA_W    = 512,
    parameter int ID_W      = 6,
    parameter int IN_DEPTH  = 64,
    parameter int OUT_DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ID_W-1:0]            awid,
    input  logic [7:0]                 awlen,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       wlast,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [ID_W-1:0]            bid,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ID_W-1:0]            arid,
    input  logic [7:0]                 arlen,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [ID_W-1:0]            rid,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rlast,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [DATA_W-1:0]          k_out_data,
    output logic                       k_out_valid,
    input  logic                       k_out_ready,
    input  logic [DATA_W-1:0]          k_in_data,
    input  logic                       k_in_valid,
    output logic                       k_in_ready,
    output logic [$clog2(IN_DEPTH):0]  in_count,
    output logic [$clog2(OUT_DEPTH):0] out_count
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t        w_state;
    logic [ID_W-1:0] w_id;
    logic [7:0]      w_len;
    logic [7:0]      w_cnt;
    logic            w_err;
    logic [1:0]      b_resp;
    logic            w_fire;

    r_state_t        r_state;
    logic [ID_W-1:0] r_id;
    logic [7:0]      r_len;
    logic [7:0]      r_cnt;
    logic            r_fire;

    logic in_full;
    logic in_empty;
    logic out_full;
    logic out_empty;

    pcis_stream_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_fire),
        .push_data (wdata),
        .pop       (k_out_ready),
        .head      (k_out_data),
        .full      (in_full),
        .empty     (in_empty),
        .count     (in_count)
    );

    pcis_stream_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (k_in_valid),
        .push_data (k_in_data),
        .pop       (r_fire),
        .head      (rdata),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

    assign k_out_valid = !in_empty;
    assign k_in_ready  = !out_full;

    assign awready = (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA) && !in_full;
    assign w_fire  = wvalid && wready;
    assign bvalid  = (w_state == W_RESP);
    assign bid     = w_id;
    assign bresp   = b_resp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            b_resp  <= 2'b00;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (awvalid) begin
                        w_id    <= awid;
                        w_len   <= awlen;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_cnt <= w_cnt + 1'b1;
                        // burst length comes from awlen; wlast only grades it
                        if (w_cnt == w_len) begin
                            b_resp  <= (w_err || !wlast) ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end else if (wlast) begin
                            w_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA) && !out_empty;
    assign rlast   = (r_state == R_DATA) && (r_cnt == r_len);
    assign r_fire  = rvalid && rready;
    assign rid     = r_id;
    assign rresp   = 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_id    <= arid;
                        r_len   <= arlen;
                        r_cnt   <= '0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == r_len) r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcis_stream_bridge.sv
// tb_pcis_stream_bridge: randomized AXI/kernel traffic checked against
// queue-based models of the write and read data paths.
module tb_pcis_stream_bridge;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 6;
    localparam int IN_DEPTH  = 4;
    localparam int OUT_DEPTH = 8;
    localparam int ICW       = $clog2(IN_DEPTH) + 1;
    localparam int OCW       = $clog2(OUT_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] k_out_data;
    logic              k_out_valid;
    logic              k_out_ready;
    logic [DATA_W-1:0] k_in_data;
    logic              k_in_valid;
    logic              k_in_ready;
    logic [ICW-1:0]    in_count;
    logic [OCW-1:0]    out_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] kq[$];
    logic [DATA_W-1:0] rq[$];
    bit src_done;

    pcis_stream_bridge #(
        .DATA_W(DATA_W), .ID_W(ID_W),
        .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .k_out_data(k_out_data), .k_out_valid(k_out_valid),
        .k_out_ready(k_out_ready),
        .k_in_data(k_in_data), .k_in_valid(k_in_valid),
        .k_in_ready(k_in_ready),
        .in_count(in_count), .out_count(out_count)
    );

    always #5 clk = ~clk;

    // Inputs change at negedge; #1 later the bench knows which handshakes
    // will occur at the coming posedge, since ready/valid depend only on state.
    task automatic do_traffic(
        input int wlen, input logic [ID_W-1:0] wid_v, input bit early,
        input bit fixed, input int kpct,
        input int rlen, input logic [ID_W-1:0] rid_v, input bit kin_first,
        input int rpct
    );
        kq.delete();
        rq.delete();
        src_done = 1'b0;
        fork
            begin : w_master
                if (wlen >= 0) begin
                    int beat = 0;
                    int cyc = 0;
                    logic [1:0] exp_resp;
                    exp_resp = (early && wlen > 0) ? 2'b10 : 2'b00;
                    @(negedge clk);
                    awid = wid_v; awlen = 8'(wlen); awvalid = 1'b1;
                    #1;
                    while (!awready && cyc < 200) begin
                        @(negedge clk); cyc++; #1;
                    end
                    @(negedge clk);
                    awvalid = 1'b0;
                    while (beat <= wlen && cyc < 600) begin
                        wvalid = ($urandom_range(0, 3) != 0);
                        wdata = fixed ? DATA_W'(10 + beat) : DATA_W'($urandom);
                        wlast = (beat == wlen) || (early && beat == 0);
                        #1;
                        if (wvalid && wready) begin
                            kq.push_back(wdata);
                            beat++;
                        end
                        @(negedge clk); cyc++;
                    end
                    wvalid = 1'b0; wlast = 1'b0;
                    bready = 1'b0;
                    #1;
                    while (!(bvalid && bready) && cyc < 800) begin
                        @(negedge clk); cyc++;
                        bready = ($urandom_range(0, 1) == 1);
                        #1;
                    end
                    n_checks++;
                    if (!(bvalid && bready)) begin
                        n_errors++;
                        $display("FAIL b_timeout: beats=%0d required=%0d", beat, wlen + 1);
                    end else begin
                        n_checks++;
                        if ({bid, bresp} !== {wid_v, exp_resp}) begin
                            n_errors++;
                            $display("FAIL b_resp: bid=%0h bresp=%b required bid=%0h bresp=%b",
                                     bid, bresp, wid_v, exp_resp);
                        end
                    end
                    @(negedge clk);
                    bready = 1'b0;
                    #1;
                    n_checks++;
                    if (bvalid !== 1'b0 || awready !== 1'b1) begin
                        n_errors++;
                        $display("FAIL b_single: bvalid=%b awready=%b required 0 1", bvalid, awready);
                    end
                end
            end
            begin : k_sink
                int got = 0;
                int cyc = 0;
                bit stalled = 0;
                logic [DATA_W-1:0] hold = '0;
                logic [DATA_W-1:0] exp;
                while (wlen >= 0 && got <= wlen && cyc < 2000) begin
                    @(negedge clk); cyc++;
                    k_out_ready = ($urandom_range(0, 99) < kpct);
                    #1;
                    n_checks++;
                    if (in_count > ICW'(IN_DEPTH)) begin
                        n_errors++;
                        $display("FAIL in_count_range: in_count=%0d required <=%0d", in_count, IN_DEPTH);
                    end
                    if (stalled) begin
                        n_checks++;
                        if (!k_out_valid || k_out_data !== hold) begin
                            n_errors++;
                            $display("FAIL k_out_stable: valid=%b data=%0h required 1 %0h",
                                     k_out_valid, k_out_data, hold);
                        end
                    end
                    stalled = k_out_valid && !k_out_ready;
                    hold = k_out_data;
                    if (k_out_valid && k_out_ready) begin
                        exp = (kq.size() > 0) ? kq.pop_front() : 'x;
                        n_checks++;
                        if (k_out_data !== exp) begin
                            n_errors++;
                            $display("FAIL k_out_data: beat %0d got %0h required %0h", got, k_out_data, exp);
                        end
                        got++;
                    end
                end
                if (wlen >= 0 && got <= wlen) begin
                    n_checks++; n_errors++;
                    $display("FAIL k_out_timeout: got=%0d required=%0d", got, wlen + 1);
                end
                @(negedge clk);
                k_out_ready = 1'b0;
            end
            begin : k_source
                int sent = 0;
                int cyc = 0;
                while (sent <= rlen && cyc < 2000) begin
                    @(negedge clk); cyc++;
                    k_in_valid = ($urandom_range(0, 2) != 0);
                    k_in_data = DATA_W'($urandom);
                    #1;
                    if (k_in_valid && k_in_ready) begin
                        rq.push_back(k_in_data);
                        sent++;
                    end
                end
                @(negedge clk);
                k_in_valid = 1'b0;
                src_done = 1'b1;
            end
            begin : r_master
                if (rlen >= 0) begin
                    int beat = 0;
                    int cyc = 0;
                    bit stalled = 0;
                    logic [DATA_W-1:0] hold = '0;
                    logic [DATA_W-1:0] exp;
                    if (kin_first) wait (src_done);
                    @(negedge clk);
                    arid = rid_v; arlen = 8'(rlen); arvalid = 1'b1;
                    #1;
                    while (!arready && cyc < 200) begin
                        @(negedge clk); cyc++; #1;
                    end
                    @(negedge clk);
                    arvalid = 1'b0;
                    while (beat <= rlen && cyc < 2000) begin
                        rready = ($urandom_range(0, 99) < rpct);
                        #1;
                        n_checks++;
                        if (out_count > OCW'(OUT_DEPTH)) begin
                            n_errors++;
                            $display("FAIL out_count_range: out_count=%0d required <=%0d",
                                     out_count, OUT_DEPTH);
                        end
                        if (stalled) begin
                            n_checks++;
                            if (!rvalid || rdata !== hold) begin
                                n_errors++;
                                $display("FAIL r_stable: rvalid=%b rdata=%0h required 1 %0h",
                                         rvalid, rdata, hold);
                            end
                        end
                        stalled = rvalid && !rready;
                        hold = rdata;
                        if (rvalid && rready) begin
                            exp = (rq.size() > 0) ? rq.pop_front() : 'x;
                            n_checks++;
                            if ({rdata, rid, rresp, rlast} !== {exp, rid_v, 2'b00, beat == rlen}) begin
                                n_errors++;
                                $display("FAIL r_beat: beat %0d rdata=%0h rid=%0h rresp=%b rlast=%b required %0h %0h 00 %b",
                                         beat, rdata, rid, rresp, rlast, exp, rid_v, beat == rlen);
                            end
                            beat++;
                        end
                        @(negedge clk); cyc++;
                    end
                    rready = 1'b0;
                    #1;
                    n_checks++;
                    if (beat <= rlen || arready !== 1'b1 || rvalid !== 1'b0) begin
                        n_errors++;
                        $display("FAIL r_done: beats=%0d arready=%b rvalid=%b required %0d 1 0",
                                 beat, arready, rvalid, rlen + 1);
                    end
                end
            end
        join
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({bvalid, rvalid, rlast, k_out_valid, awready, arready, wready, k_in_ready}
            !== 8'b0000_1101) begin
            n_errors++;
            $display("FAIL reset_ctrl: bv rv rl kv awr arr wr kir=%b%b%b%b%b%b%b%b required 00001101",
                     bvalid, rvalid, rlast, k_out_valid, awready, arready, wready, k_in_ready);
        end
        n_checks++;
        if ({bresp, rresp, bid, rid, in_count, out_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_vals: bresp=%b rresp=%b bid=%0h rid=%0h in=%0d out=%0d required all 0",
                     bresp, rresp, bid, rid, in_count, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_write();
        do_traffic(3, 6'h2A, 1'b0, 1'b1, 70, -1, '0, 1'b0, 0);
    endtask

    task automatic test_early_wlast();
        do_traffic(1, 6'h11, 1'b1, 1'b0, 80, -1, '0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        int beat = 0;
        int got = 0;
        int cyc = 0;
        @(negedge clk);
        awid = 6'h05; awlen = 8'd5; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        k_out_ready = 1'b0;
        wvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wdata = DATA_W'(100 + beat);
            wlast = (beat == 5);
            #1;
            if (wvalid && wready) beat++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (beat != 4 || in_count !== ICW'(4) || wready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_full: beats=%0d in_count=%0d wready=%b required 4 4 0",
                     beat, in_count, wready);
        end
        while ((got < 6 || beat < 6) && cyc < 100) begin
            k_out_ready = 1'b1;
            wvalid = (beat < 6);
            wdata = DATA_W'(100 + beat);
            wlast = (beat == 5);
            #1;
            if (k_out_valid) begin
                n_checks++;
                if (k_out_data !== DATA_W'(100 + got)) begin
                    n_errors++;
                    $display("FAIL bp_data: beat %0d got %0h required %0h", got, k_out_data, 100 + got);
                end
                got++;
            end
            if (wvalid && wready) beat++;
            @(negedge clk); cyc++;
        end
        wvalid = 1'b0; wlast = 1'b0; k_out_ready = 1'b0;
        bready = 1'b1;
        #1;
        n_checks++;
        if (got != 6 || {bvalid, bresp, bid} !== {1'b1, 2'b00, 6'h05}) begin
            n_errors++;
            $display("FAIL bp_done: got=%0d bvalid=%b bresp=%b bid=%0h required 6 1 00 05",
                     got, bvalid, bresp, bid);
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic test_read_burst();
        do_traffic(-1, '0, 1'b0, 1'b0, 0, 7, 6'h33, 1'b1, 50);
    endtask

    task automatic test_reset_mid_burst();
        int beat = 0;
        int kin = 0;
        int cyc = 0;
        @(negedge clk);
        awid = 6'h09; awlen = 8'd7; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        k_out_ready = 1'b0;
        while ((beat < 3 || kin < 2) && cyc < 50) begin
            wvalid = (beat < 3);
            wdata = DATA_W'(200 + beat);
            wlast = 1'b0;
            k_in_valid = (kin < 2);
            k_in_data = DATA_W'(300 + kin);
            #1;
            if (wvalid && wready) beat++;
            if (k_in_valid && k_in_ready) kin++;
            @(negedge clk); cyc++;
        end
        wvalid = 1'b0; k_in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_count !== ICW'(3) || out_count !== OCW'(2)) begin
            n_errors++;
            $display("FAIL mid_fill: in=%0d out=%0d required 3 2", in_count, out_count);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({in_count, out_count} !== '0 || bvalid !== 1'b0 || awready !== 1'b1 ||
            k_out_valid !== 1'b0 || wready !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: in=%0d out=%0d bvalid=%b awready=%b kv=%b wready=%b required 0 0 0 1 0 0",
                     in_count, out_count, bvalid, awready, k_out_valid, wready);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_no_b: bvalid=%b required 0", bvalid);
        end
        do_traffic(7, 6'h0C, 1'b0, 1'b0, 60, -1, '0, 1'b0, 0);
    endtask

    task automatic test_concurrent();
        do_traffic(15, 6'h01, 1'b0, 1'b0, 60, 15, 6'h3E, 1'b0, 60);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            do_traffic($urandom_range(0, 12), 6'($urandom), bit'($urandom_range(0, 1)), 1'b0,
                       $urandom_range(30, 90), $urandom_range(0, 12), 6'($urandom), 1'b0,
                       $urandom_range(30, 90));
        end
    endtask

    initial begin
        awid = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        k_out_ready = 1'b0; k_in_data = '0; k_in_valid = 1'b0;
        test_reset();
        test_basic_write();
        test_early_wlast();
        test_backpressure();
        test_read_burst();
        test_reset_mid_burst();
        test_concurrent();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
